// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Readiness-scoreboard hazard unit sitting beside a 5-stage MIPS-style
//   datapath. Each architectural register has a small countdown of cycles
//   until its pending result can be consumed; D-stage operands are checked
//   against it instead of comparing register numbers stage by stage. The
//   unit also tracks an occupied multi-cycle divider and registers the
//   exception / ERET redirect target.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   issue_validD                   valid instruction in D
//   rsD, rtD, rs_useD, rt_useD     source registers and whether each is read
//   early_useD                     operands consumed in D (branch, jr, jalr)
//   regwriteD, memtoregD, writeregD  destination write info (load flag)
//   div_startD, div_done           divider start in D / divider completion
//   i_stall, d_stall               cache stalls
//   except_typeM, cp0_epcM         M-stage exception code and EPC
//   stallF..stallW, flushF..flushW pipeline stage controls
//   div_busy                       divider occupied
//   redirect_valid, newPC          one-cycle redirect pulse and its target
module hazard_scoreboard #(
  parameter int          NREG       = 32,
  parameter int          CNT_W      = 3,
  parameter int          ALU_LAT    = 0,
  parameter int          LOAD_LAT   = 1,
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
  parameter logic [31:0] ERET_CODE  = 32'h0000000e
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_validD,
  input  logic [4:0]  rsD,
  input  logic [4:0]  rtD,
  input  logic        rs_useD,
  input  logic        rt_useD,
  input  logic        early_useD,
  input  logic        regwriteD,
  input  logic        memtoregD,
  input  logic [4:0]  writeregD,
  input  logic        div_startD,
  input  logic        div_done,
  input  logic        i_stall,
  input  logic        d_stall,
  input  logic [31:0] except_typeM,
  input  logic [31:0] cp0_epcM,
  output logic        stallF,
  output logic        stallD,
  output logic        stallE,
  output logic        stallM,
  output logic        stallW,
  output logic        flushF,
  output logic        flushD,
  output logic        flushE,
  output logic        flushM,
  output logic        flushW,
  output logic        div_busy,
  output logic        redirect_valid,
  output logic [31:0] newPC
);

  localparam logic [CNT_W-1:0] ALU_INIT  = CNT_W'(ALU_LAT + 1);
  localparam logic [CNT_W-1:0] LOAD_INIT = CNT_W'(LOAD_LAT + 1);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  // Entry 0 exists only so rsD/rtD can index directly; it is held at zero.
  logic [NREG-1:0][CNT_W-1:0] cntReg;
  logic [NREG-1:0][CNT_W-1:0] cntNext;
  logic                       divBusyReg;
  logic                       redirectValidReg;
  logic [31:0]                newPcReg;

  logic           except;
  logic           memStall;
  logic           backStall;
  logic           rsHazard;
  logic           rtHazard;
  logic           depStall;
  logic           divConflict;
  logic           frontHold;
  logic           excTake;
  logic           frontStall;
  logic           issue;
  logic           trackWrite;
  logic [CNT_W-1:0] writeInit;

  assign except    = |except_typeM;
  assign memStall  = i_stall | d_stall;
  assign backStall = memStall | (divBusyReg & ~div_done);

  // A consumer in E can take a result once its count reaches 1 (forwarded
  // next cycle); a consumer in D needs the count to have reached 0.
  assign rsHazard = rs_useD && (rsD != 5'd0) &&
                    (early_useD ? (cntReg[rsD] != '0) : (cntReg[rsD] > ONE));
  assign rtHazard = rt_useD && (rtD != 5'd0) &&
                    (early_useD ? (cntReg[rtD] != '0) : (cntReg[rtD] > ONE));

  assign depStall    = issue_validD & (rsHazard | rtHazard);
  assign divConflict = issue_validD & div_startD & divBusyReg & ~div_done;
  assign frontHold   = depStall | divConflict;
  // An exception waits for the memory stall to clear so the M stage holds it.
  assign excTake     = except & ~memStall;
  assign frontStall  = frontHold | backStall;

  assign stallF = frontStall;
  assign stallD = frontStall;
  assign stallE = backStall;
  assign stallM = backStall;
  assign stallW = backStall;

  // A held D instruction leaves a bubble in E, unless the back end is frozen
  // too (then E keeps its own instruction).
  assign flushE = (frontHold & ~backStall & ~except) | excTake;
  assign flushF = excTake;
  assign flushD = excTake;
  assign flushM = excTake;
  assign flushW = excTake;

  assign issue      = issue_validD & ~frontStall & ~except;
  assign trackWrite = issue & regwriteD & (writeregD != 5'd0);
  assign writeInit  = memtoregD ? LOAD_INIT : ALU_INIT;

  // Per-entry next count: exception flush beats a fresh write, which beats
  // the normal countdown; everything freezes while the back end is stalled.
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : gEntry
      if (gi == 0) begin : gZero
        assign cntNext[gi] = '0;
      end else begin : gTracked
        assign cntNext[gi] =
          excTake                                    ? '0 :
          (trackWrite && (writeregD == 5'(gi)))      ? writeInit :
          (!backStall && (cntReg[gi] != '0))         ? cntReg[gi] - ONE :
                                                       cntReg[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      cntReg           <= '0;
      divBusyReg       <= 1'b0;
      redirectValidReg <= 1'b0;
      newPcReg         <= EXC_VECTOR;
    end else begin
      cntReg <= cntNext;
      // Divider keeps running across an exception; a new start wins over
      // the completion of the previous one.
      if (issue && div_startD)
        divBusyReg <= 1'b1;
      else if (div_done)
        divBusyReg <= 1'b0;
      redirectValidReg <= excTake;
      if (excTake)
        newPcReg <= (except_typeM == ERET_CODE) ? cp0_epcM : EXC_VECTOR;
    end
  end

  assign div_busy       = divBusyReg;
  assign redirect_valid = redirectValidReg;
  assign newPC          = newPcReg;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: a cycle-by-cycle table of
// inputs and hand-computed expected outputs, then a hand-written sequence
// for reset in the middle of activity.
module tb_hazard_scoreboard;

  localparam logic [31:0] Z  = 32'h0;
  localparam logic [31:0] X4 = 32'h4;
  localparam logic [31:0] XE = 32'hE;
  localparam logic [31:0] EV = 32'hBFC00380;
  localparam logic [31:0] EP = 32'hBFC00100;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_validD;
  logic [4:0]  rsD, rtD;
  logic        rs_useD, rt_useD, early_useD;
  logic        regwriteD, memtoregD;
  logic [4:0]  writeregD;
  logic        div_startD, div_done;
  logic        i_stall, d_stall;
  logic [31:0] except_typeM, cp0_epcM;
  logic        stallF, stallD, stallE, stallM, stallW;
  logic        flushF, flushD, flushE, flushM, flushW;
  logic        div_busy, redirect_valid;
  logic [31:0] newPC;

  int nVec = 0;
  int nMis = 0;

  hazard_scoreboard dut (
    .clk(clk), .rst(rst),
    .issue_validD(issue_validD), .rsD(rsD), .rtD(rtD),
    .rs_useD(rs_useD), .rt_useD(rt_useD), .early_useD(early_useD),
    .regwriteD(regwriteD), .memtoregD(memtoregD), .writeregD(writeregD),
    .div_startD(div_startD), .div_done(div_done),
    .i_stall(i_stall), .d_stall(d_stall),
    .except_typeM(except_typeM), .cp0_epcM(cp0_epcM),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM), .stallW(stallW),
    .flushF(flushF), .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
    .div_busy(div_busy), .redirect_valid(redirect_valid), .newPC(newPC)
  );

  always #5 clk = ~clk;

  // inputs: iv rs rt ru tu ea rw mr wr ds dd is dst exc epc
  // expect: sD(F,D) sE(E,M,W) fE fX(F,D,M,W) bz rd pc, probe cnt[ci]==cv
  typedef struct {
    int iv; int rs; int rt; int ru; int tu; int ea; int rw; int mr; int wr;
    int ds; int dd; int is; int dst;
    logic [31:0] exc; logic [31:0] epc;
    int sD; int sE; int fE; int fX; int bz; int rd;
    logic [31:0] pc; int ci; int cv;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [11:0] ctlNow();
    return {stallF, stallD, stallE, stallM, stallW,
            flushF, flushD, flushE, flushM, flushW, div_busy, redirect_valid};
  endfunction

  task automatic drive(input vec_t v);
    issue_validD = v.iv[0];  rsD = 5'(v.rs);  rtD = 5'(v.rt);
    rs_useD = v.ru[0];  rt_useD = v.tu[0];  early_useD = v.ea[0];
    regwriteD = v.rw[0];  memtoregD = v.mr[0];  writeregD = 5'(v.wr);
    div_startD = v.ds[0];  div_done = v.dd[0];
    i_stall = v.is[0];  d_stall = v.dst[0];
    except_typeM = v.exc;  cp0_epcM = v.epc;
  endtask

  task automatic idle();
    issue_validD = 0; rsD = 0; rtD = 0; rs_useD = 0; rt_useD = 0; early_useD = 0;
    regwriteD = 0; memtoregD = 0; writeregD = 0; div_startD = 0; div_done = 0;
    i_stall = 0; d_stall = 0; except_typeM = 0; cp0_epcM = 0;
  endtask

  task automatic checkVec(input int idx, input vec_t v);
    logic [11:0] act, exp;
    logic [2:0]  cAct;
    act  = ctlNow();
    exp  = {v.sD[0], v.sD[0], v.sE[0], v.sE[0], v.sE[0],
            v.fX[0], v.fX[0], v.fE[0], v.fX[0], v.fX[0], v.bz[0], v.rd[0]};
    cAct = dut.cntReg[v.ci];
    nVec++;
    if (act !== exp || newPC !== v.pc || cAct !== 3'(v.cv)) begin
      nMis++;
      $display("FAIL vec%0d: ctl=%b pc=%h cnt[%0d]=%0d, expected ctl=%b pc=%h cnt=%0d",
               idx, act, newPC, v.ci, cAct, exp, v.pc, v.cv);
    end else begin
      $display("vec%0d ok: ctl=%b pc=%h cnt[%0d]=%0d", idx, act, newPC, v.ci, cAct);
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("%s ok: %h", name, act);
    end
  endtask

  initial begin
    //            iv rs rt ru tu ea rw mr wr ds dd is dst exc epc  sD sE fE fX bz rd pc  ci cv
    // load r5, dependent add stalls once, cnt[5] 2 -> 1 -> 0
    vecs.push_back('{1, 0, 0, 0, 0, 0, 1, 1, 5, 0, 0, 0, 0, Z,  Z,   0, 0, 0, 0, 0, 0, EV, 5, 0});
    vecs.push_back('{1, 5, 0, 1, 0, 0, 1, 0, 6, 0, 0, 0, 0, Z,  Z,   1, 0, 1, 0, 0, 0, EV, 5, 2});
    vecs.push_back('{1, 5, 0, 1, 0, 0, 1, 0, 6, 0, 0, 0, 0, Z,  Z,   0, 0, 0, 0, 0, 0, EV, 5, 1});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, Z,  Z,   0, 0, 0, 0, 0, 0, EV, 5, 0});
    // ALU r3, early-use beq stalls once; plain add reading r3 does not
    vecs.push_back('{1, 0, 0, 0, 0, 0, 1, 0, 3, 0, 0, 0, 0, Z,  Z,   0, 0, 0, 0, 0, 0, EV, 3, 0});
    vecs.push_back('{1, 3, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, Z,  Z,   1, 0, 1, 0, 0, 0, EV, 3, 1});
    vecs.push_back('{1, 3, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, Z,  Z,   0, 0, 0, 0, 0, 0, EV, 3, 0});
    vecs.push_back('{1, 0, 0, 0, 0, 0, 1, 0, 3, 0, 0, 0, 0, Z,  Z,   0, 0, 0, 0, 0, 0, EV, 3, 0});
    vecs.push_back('{1, 0, 3, 0, 1, 0, 1, 0, 4, 0, 0, 0, 0, Z,  Z,   0, 0, 0, 0, 0, 0, EV, 3, 1});
    // load r5 then d_stall for 4 cycles with a dependent add waiting in D
    vecs.push_back('{1, 0, 0, 0, 0, 0, 1, 1, 5, 0, 0, 0, 0, Z,  Z,   0, 0, 0, 0, 0, 0, EV, 5, 0});
    for (int k = 0; k < 4; k++)
      vecs.push_back('{1, 5, 0, 1, 0, 0, 1, 0, 6, 0, 0, 0, 1, Z,  Z,   1, 1, 0, 0, 0, 0, EV, 5, 2});
    vecs.push_back('{1, 5, 0, 1, 0, 0, 1, 0, 6, 0, 0, 0, 0, Z,  Z,   1, 0, 1, 0, 0, 0, EV, 5, 2});
    vecs.push_back('{1, 5, 0, 1, 0, 0, 1, 0, 6, 0, 0, 0, 0, Z,  Z,   0, 0, 0, 0, 0, 0, EV, 5, 1});
    // back-to-back dividers
    vecs.push_back('{1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, Z,  Z,   0, 0, 0, 0, 0, 0, EV, 6, 1});
    vecs.push_back('{1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, Z,  Z,   1, 1, 0, 0, 1, 0, EV, 6, 0});
    vecs.push_back('{1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, Z,  Z,   1, 1, 0, 0, 1, 0, EV, 6, 0});
    vecs.push_back('{1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, Z,  Z,   0, 0, 0, 0, 1, 0, EV, 6, 0});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, Z,  Z,   1, 1, 0, 0, 1, 0, EV, 6, 0});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, Z,  Z,   0, 0, 0, 0, 1, 0, EV, 6, 0});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, Z,  Z,   0, 0, 0, 0, 0, 0, EV, 6, 0});
    // exception with cnt[7]=2, then ERET to EPC
    vecs.push_back('{1, 0, 0, 0, 0, 0, 1, 1, 7, 0, 0, 0, 0, Z,  Z,   0, 0, 0, 0, 0, 0, EV, 7, 0});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, X4, Z,   0, 0, 1, 1, 0, 0, EV, 7, 2});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, Z,  Z,   0, 0, 0, 0, 0, 1, EV, 7, 0});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, Z,  Z,   0, 0, 0, 0, 0, 0, EV, 7, 0});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, XE, EP,  0, 0, 1, 1, 0, 0, EV, 7, 0});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, Z,  Z,   0, 0, 0, 0, 0, 1, EP, 7, 0});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, Z,  Z,   0, 0, 0, 0, 0, 0, EP, 7, 0});
    // exception deferred by i_stall, then taken
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, X4, Z,   1, 1, 0, 0, 0, 0, EP, 7, 0});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, X4, Z,   0, 0, 1, 1, 0, 0, EP, 7, 0});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, Z,  Z,   0, 0, 0, 0, 0, 1, EV, 7, 0});
    // load in D alongside an exception is not recorded
    vecs.push_back('{1, 0, 0, 0, 0, 0, 1, 1, 8, 0, 0, 0, 0, X4, Z,   0, 0, 1, 1, 0, 0, EV, 8, 0});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, Z,  Z,   0, 0, 0, 0, 0, 1, EV, 8, 0});
    // load to r0 never tracked; early-use read of r0 never stalls
    vecs.push_back('{1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, Z,  Z,   0, 0, 0, 0, 0, 0, EV, 0, 0});
    vecs.push_back('{1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, Z,  Z,   0, 0, 0, 0, 0, 0, EV, 0, 0});

    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_state", {20'b0, ctlNow(), newPC}, {20'b0, 12'b0, EV});
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      drive(vecs[i]);
      @(negedge clk);
      checkVec(i, vecs[i]);
      @(posedge clk); #1;
    end

    // Reset mid-operation: load r9 that also starts the divider.
    idle();
    issue_validD = 1; div_startD = 1; regwriteD = 1; memtoregD = 1; writeregD = 5'd9;
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    chk("pre_reset_busy", {60'b0, div_busy, stallE, dut.cntReg[9][1:0]}, {60'b0, 1'b1, 1'b1, 2'd2});
    @(posedge clk); #1;
    // Reset edge with a load r10 that would otherwise issue.
    issue_validD = 1; regwriteD = 1; memtoregD = 1; writeregD = 5'd10; div_done = 1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle();
    @(negedge clk);
    chk("post_reset_cnt", {58'b0, dut.cntReg[9], dut.cntReg[10]}, 64'd0);
    chk("post_reset_ctl", {20'b0, ctlNow(), newPC}, {20'b0, 12'b0, EV});

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
